uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_parser.sv | 101 ++++++++++
 tb/tb_uart_cmd_parser.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// Five-byte command frame parser fed by a UART receiver: SYNC, CMD, DATA_HI, DATA_LO, CHK.
// Accepts frames whose XOR checksum matches and abandons a frame when the line goes quiet too long.
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         TIMEOUT_TICKS = 640
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_done_tick,
    input  logic [7:0]  rx_byte,
    input  logic        sample_tick,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [15:0] cmd_data,
    output logic        chk_err,
    output logic        timeout_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        HUNT,
        GET_CMD,
        GET_DHI,
        GET_DLO,
        GET_CHK
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_TICKS - 1);

    state_t      state, state_next;
    logic [15:0] tmo_cnt;
    logic [7:0]  hold_cmd, hold_dhi, hold_dlo;
    logic        frame_ok, frame_bad, tmo_hit;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        tmo_hit    = 1'b0;
        if (rx_done_tick) begin
            // A byte always beats an expiring timeout in the same cycle.
            case (state)
                HUNT:    if (rx_byte == SYNC_BYTE) state_next = GET_CMD;
                GET_CMD: state_next = GET_DHI;
                GET_DHI: state_next = GET_DLO;
                GET_DLO: state_next = GET_CHK;
                GET_CHK: begin
                    state_next = HUNT;
                    if (rx_byte == (hold_cmd ^ hold_dhi ^ hold_dlo)) frame_ok = 1'b1;
                    else                                             frame_bad = 1'b1;
                end
                default: state_next = HUNT;
            endcase
        end else if (state != HUNT && sample_tick && tmo_cnt == TMO_LAST) begin
            tmo_hit    = 1'b1;
            state_next = HUNT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            tmo_cnt     <= '0;
            hold_cmd    <= '0;
            hold_dhi    <= '0;
            hold_dlo    <= '0;
            cmd_code    <= '0;
            cmd_data    <= '0;
            cmd_valid   <= 1'b0;
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            cmd_valid   <= frame_ok;
            chk_err     <= frame_bad;
            timeout_err <= tmo_hit;

            if (state == HUNT || rx_done_tick || tmo_hit) tmo_cnt <= '0;
            else if (sample_tick)                         tmo_cnt <= tmo_cnt + 16'd1;

            if (rx_done_tick) begin
                case (state)
                    GET_CMD: hold_cmd <= rx_byte;
                    GET_DHI: hold_dhi <= rx_byte;
                    GET_DLO: hold_dlo <= rx_byte;
                    default: ;
                endcase
            end

            if (frame_ok) begin
                cmd_code <= hold_cmd;
                cmd_data <= {hold_dhi, hold_dlo};
            end
        end
    end

    assign busy = (state != HUNT);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: good/bad frames, hunting, timeout boundary, reset and back-to-back frames.
module tb_uart_cmd_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_done_tick = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        sample_tick = 1'b0;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [15:0] cmd_data;
    logic        chk_err;
    logic        timeout_err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Pulse tallies, taken mid-cycle when outputs are stable.
    int n_valid = 0, n_chk = 0, n_tmo = 0, n_overlap = 0;
    int v0, c0, t0;

    uart_cmd_parser dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_byte      (rx_byte),
        .sample_tick  (sample_tick),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code),
        .cmd_data     (cmd_data),
        .chk_err      (chk_err),
        .timeout_err  (timeout_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid === 1'b1)   n_valid++;
        if (chk_err === 1'b1)     n_chk++;
        if (timeout_err === 1'b1) n_tmo++;
        if (int'(cmd_valid === 1'b1) + int'(chk_err === 1'b1) + int'(timeout_err === 1'b1) > 1)
            n_overlap++;
    end

    // Drive one byte for one cycle; returns at the negedge after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_byte      = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        send_byte(b4);
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic snap();
        v0 = n_valid;
        c0 = n_chk;
        t0 = n_tmo;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset        = 1'b1;
        rx_byte      = 8'hA5;
        rx_done_tick = 1'b1;
        sample_tick  = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        n_tests++;
        if ({cmd_valid, chk_err, timeout_err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pulses: got %b expected 000", {cmd_valid, chk_err, timeout_err});
        end
        n_tests++;
        if ({cmd_code, cmd_data} !== 24'h0) begin
            n_fail++; $display("FAIL reset_cmd: got %h expected 000000", {cmd_code, cmd_data});
        end
        reset        = 1'b0;
        rx_done_tick = 1'b0;
        sample_tick  = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_valid_frame();
        snap();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        n_tests++;
        if ({busy, cmd_valid} !== 2'b10) begin
            n_fail++; $display("FAIL vf_before_chk busy,valid: got %b expected 10", {busy, cmd_valid});
        end
        send_byte(8'h27);
        n_tests++;
        if (cmd_valid !== 1'b1) begin
            n_fail++; $display("FAIL vf_latency cmd_valid: got %b expected 1", cmd_valid);
        end
        n_tests++;
        if ({cmd_code, cmd_data} !== 24'h01_1234) begin
            n_fail++; $display("FAIL vf_cmd: got %h expected 011234", {cmd_code, cmd_data});
        end
        @(negedge clk);
        n_tests++;
        if ({cmd_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL vf_one_cycle valid,busy: got %b expected 00", {cmd_valid, busy});
        end
        settle();
        n_tests++;
        if ({n_valid - v0, n_chk - c0, n_tmo - t0} !== {32'd1, 32'd0, 32'd0}) begin
            n_fail++; $display("FAIL vf_counts v/c/t: got %0d/%0d/%0d expected 1/0/0", n_valid - v0, n_chk - c0, n_tmo - t0);
        end
    endtask

    task automatic test_bad_checksum();
        snap();
        send_frame(8'hA5, 8'h01, 8'h12, 8'h34, 8'h28);
        n_tests++;
        if (chk_err !== 1'b1) begin
            n_fail++; $display("FAIL bad_latency chk_err: got %b expected 1", chk_err);
        end
        send_frame(8'hA5, 8'h55, 8'h66, 8'h77, 8'h00);
        settle();
        n_tests++;
        if ({n_valid - v0, n_chk - c0, n_tmo - t0} !== {32'd0, 32'd2, 32'd0}) begin
            n_fail++; $display("FAIL bad_counts v/c/t: got %0d/%0d/%0d expected 0/2/0", n_valid - v0, n_chk - c0, n_tmo - t0);
        end
        n_tests++;
        if ({cmd_code, cmd_data} !== 24'h01_1234) begin
            n_fail++; $display("FAIL bad_hold_cmd: got %h expected 011234", {cmd_code, cmd_data});
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL bad_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_hunt_skip();
        snap();
        send_byte(8'h00);
        send_byte(8'hFF);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL hunt_ignore busy: got %b expected 0", busy);
        end
        send_frame(8'hA5, 8'h02, 8'h00, 8'h10, 8'h12);
        settle();
        n_tests++;
        if ({n_valid - v0, n_chk - c0, n_tmo - t0} !== {32'd1, 32'd0, 32'd0}) begin
            n_fail++; $display("FAIL hunt_counts v/c/t: got %0d/%0d/%0d expected 1/0/0", n_valid - v0, n_chk - c0, n_tmo - t0);
        end
        n_tests++;
        if ({cmd_code, cmd_data} !== 24'h02_0010) begin
            n_fail++; $display("FAIL hunt_cmd: got %h expected 020010", {cmd_code, cmd_data});
        end
    endtask

    task automatic test_sync_in_frame();
        snap();
        send_frame(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
        settle();
        n_tests++;
        if ({n_valid - v0, n_chk - c0} !== {32'd1, 32'd0}) begin
            n_fail++; $display("FAIL sync_counts v/c: got %0d/%0d expected 1/0", n_valid - v0, n_chk - c0);
        end
        n_tests++;
        if ({cmd_code, cmd_data} !== 24'hA5_A5A5) begin
            n_fail++; $display("FAIL sync_cmd: got %h expected A5A5A5", {cmd_code, cmd_data});
        end
    endtask

    task automatic test_timeout();
        snap();
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (639) tick();
        settle();
        n_tests++;
        if ({n_tmo - t0, 31'd0, busy} !== {32'd0, 31'd0, 1'b1}) begin
            n_fail++; $display("FAIL tmo_639 tmo,busy: got %0d,%b expected 0,1", n_tmo - t0, busy);
        end
        tick();
        settle();
        n_tests++;
        if ({n_tmo - t0, 31'd0, busy} !== {32'd1, 31'd0, 1'b0}) begin
            n_fail++; $display("FAIL tmo_640 tmo,busy: got %0d,%b expected 1,0", n_tmo - t0, busy);
        end
        send_frame(8'hA5, 8'h03, 8'h00, 8'h01, 8'h02);
        settle();
        n_tests++;
        if ({n_valid - v0, n_chk - c0, n_tmo - t0} !== {32'd1, 32'd0, 32'd1}) begin
            n_fail++; $display("FAIL tmo_counts v/c/t: got %0d/%0d/%0d expected 1/0/1", n_valid - v0, n_chk - c0, n_tmo - t0);
        end
        n_tests++;
        if ({cmd_code, cmd_data} !== 24'h03_0001) begin
            n_fail++; $display("FAIL tmo_cmd: got %h expected 030001", {cmd_code, cmd_data});
        end
    endtask

    task automatic test_timeout_race();
        snap();
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (639) tick();
        rx_byte      = 8'h12;
        rx_done_tick = 1'b1;
        sample_tick  = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        sample_tick  = 1'b0;
        repeat (5) tick();
        send_byte(8'h34);
        send_byte(8'h27);
        settle();
        n_tests++;
        if ({n_valid - v0, n_chk - c0, n_tmo - t0} !== {32'd1, 32'd0, 32'd0}) begin
            n_fail++; $display("FAIL race_counts v/c/t: got %0d/%0d/%0d expected 1/0/0", n_valid - v0, n_chk - c0, n_tmo - t0);
        end
        n_tests++;
        if ({cmd_code, cmd_data} !== 24'h01_1234) begin
            n_fail++; $display("FAIL race_cmd: got %h expected 011234", {cmd_code, cmd_data});
        end
    endtask

    task automatic test_reset_mid_frame();
        snap();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h12);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if ({busy, cmd_code, cmd_data} !== 25'h0) begin
            n_fail++; $display("FAIL rmf_cleared busy,cmd: got %h expected 0", {busy, cmd_code, cmd_data});
        end
        send_byte(8'h34);
        send_byte(8'h27);
        send_frame(8'hA5, 8'h04, 8'hAB, 8'hCD, 8'h62);
        settle();
        n_tests++;
        if ({n_valid - v0, n_chk - c0, n_tmo - t0} !== {32'd1, 32'd0, 32'd0}) begin
            n_fail++; $display("FAIL rmf_counts v/c/t: got %0d/%0d/%0d expected 1/0/0", n_valid - v0, n_chk - c0, n_tmo - t0);
        end
        n_tests++;
        if ({cmd_code, cmd_data} !== 24'h04_ABCD) begin
            n_fail++; $display("FAIL rmf_cmd: got %h expected 04ABCD", {cmd_code, cmd_data});
        end
    endtask

    task automatic test_back_to_back();
        snap();
        send_frame(8'hA5, 8'h10, 8'h20, 8'h30, 8'h00);
        send_frame(8'hA5, 8'h11, 8'h22, 8'h33, 8'h00);
        settle();
        n_tests++;
        if ({n_valid - v0, n_chk - c0, n_tmo - t0} !== {32'd2, 32'd0, 32'd0}) begin
            n_fail++; $display("FAIL b2b_counts v/c/t: got %0d/%0d/%0d expected 2/0/0", n_valid - v0, n_chk - c0, n_tmo - t0);
        end
        n_tests++;
        if ({cmd_code, cmd_data} !== 24'h11_2233) begin
            n_fail++; $display("FAIL b2b_cmd: got %h expected 112233", {cmd_code, cmd_data});
        end
        n_tests++;
        if (n_overlap !== 0) begin
            n_fail++; $display("FAIL pulse_exclusive overlaps: got %0d expected 0", n_overlap);
        end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_bad_checksum();
        test_hunt_skip();
        test_sync_in_frame();
        test_timeout();
        test_timeout_race();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
